// File: rtl/prefix_adder_pkg.sv
// Shared types and sizing helpers for the pipelined Kogge-Stone adder.
// Optional subtract mode is enabled by defining PREFIX_ADDER_SUB_EN.
package prefix_adder_pkg;

    localparam int MAX_W = 64;

    // One pipeline bank. Fields are sized for the widest legal operand and
    // zero-extended; p holds the half-sum with carry-in already folded into bit 0.
    typedef struct packed {
        logic             valid;
        logic             sub;
        logic [MAX_W-1:0] p;
        logic [MAX_W-1:0] gp;
        logic [MAX_W-1:0] gg;
    } stage_t;

    function automatic int num_levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int num_stages(input int width, input int lvl_per_stg);
        return (num_levels(width) + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

endpackage

// File: rtl/prefix_adder_pipe_pg_cell.sv
// Group propagate/generate combine for one Kogge-Stone level, N positions wide.
module pg_cell
    import prefix_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] p_hi,
    input  logic [N-1:0] g_hi,
    input  logic [N-1:0] p_lo,
    input  logic [N-1:0] g_lo,
    output logic [N-1:0] p_out,
    output logic [N-1:0] g_out
);

    assign p_out = p_hi & p_lo;
    assign g_out = g_hi | (p_hi & g_lo);

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready flow control and global stall.
// Define PREFIX_ADDER_SUB_EN to add the 'sub' port (a - b mode).
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L    = num_levels(WIDTH);
    localparam int NSTG = num_stages(WIDTH, LVL_PER_STG);

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_in;
    logic             sub_in;

`ifdef PREFIX_ADDER_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign c_in   = sub | cin;
    assign sub_in = sub;
`else
    assign b_eff  = b;
    assign c_in   = cin;
    assign sub_in = 1'b0;
`endif

    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] g0;
    assign p0 = a ^ b_eff;
    assign g0 = a & b_eff;

    // Inputs to each stage's prefix levels: index 0 comes from the ports.
    logic             src_v   [NSTG];
    logic             src_sub [NSTG];
    logic [WIDTH-1:0] src_p   [NSTG];
    logic [WIDTH-1:0] src_gp  [NSTG];
    logic [WIDTH-1:0] src_gg  [NSTG];
    stage_t           stg_d   [NSTG];
    stage_t           stg_q   [NSTG];

    // Carry-in is pre-combined into position 0, so bit 0 never needs a group P.
    assign src_v[0]   = in_valid;
    assign src_sub[0] = sub_in;
    assign src_p[0]   = {p0[WIDTH-1:1], p0[0] ^ c_in};
    assign src_gp[0]  = {p0[WIDTH-1:1], 1'b0};
    assign src_gg[0]  = {g0[WIDTH-1:1], g0[0] | (p0[0] & c_in)};

    generate
        for (genvar s = 1; s < NSTG; s++) begin : g_src
            assign src_v[s]   = stg_q[s-1].valid;
            assign src_sub[s] = stg_q[s-1].sub;
            assign src_p[s]   = stg_q[s-1].p[WIDTH-1:0];
            assign src_gp[s]  = stg_q[s-1].gp[WIDTH-1:0];
            assign src_gg[s]  = stg_q[s-1].gg[WIDTH-1:0];
        end

        for (genvar j = 0; j < L; j++) begin : g_lvl
            localparam int D = 1 << j;
            logic [WIDTH-1:0]   gp_i, gg_i, gp_o, gg_o;
            logic [WIDTH-D-1:0] gp_c, gg_c;

            if (j % LVL_PER_STG == 0) begin : g_head
                assign gp_i = src_gp[j / LVL_PER_STG];
                assign gg_i = src_gg[j / LVL_PER_STG];
            end else begin : g_chain
                assign gp_i = g_lvl[j-1].gp_o;
                assign gg_i = g_lvl[j-1].gg_o;
            end

            pg_cell #(.N(WIDTH - D)) u_pg (
                .p_hi  (gp_i[WIDTH-1:D]),
                .g_hi  (gg_i[WIDTH-1:D]),
                .p_lo  (gp_i[WIDTH-1-D:0]),
                .g_lo  (gg_i[WIDTH-1-D:0]),
                .p_out (gp_c),
                .g_out (gg_c)
            );

            assign gp_o = {gp_c, gp_i[D-1:0]};
            assign gg_o = {gg_c, gg_i[D-1:0]};
        end

        for (genvar s = 0; s < NSTG; s++) begin : g_stg
            localparam int LAST = (((s + 1) * LVL_PER_STG < L) ? (s + 1) * LVL_PER_STG : L) - 1;
            assign stg_d[s] = '{valid: src_v[s],
                                sub:   src_sub[s],
                                p:     MAX_W'(src_p[s]),
                                gp:    MAX_W'(g_lvl[LAST].gp_o),
                                gg:    MAX_W'(g_lvl[LAST].gg_o)};
        end
    endgenerate

    // After all levels, gg[i] is the carry out of bit i.
    stage_t           last;
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] sum_d;
    assign last  = stg_q[NSTG-1];
    assign g_fin = last.gg[WIDTH-1:0];
    assign sum_d = last.p[WIDTH-1:0] ^ {g_fin[WIDTH-2:0], 1'b0};

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: only valid bits and outputs are reset; datapath fields hold
            // whatever they had, which keeps reset fan-out off the wide registers.
            for (int s = 0; s < NSTG; s++) stg_q[s].valid <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            for (int s = 0; s < NSTG; s++) stg_q[s] <= stg_d[s];
            out_valid <= last.valid;
            sum       <= sum_d;
            cout      <= g_fin[WIDTH-1];
            ovf       <= g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Scoreboard bench for prefix_adder_pipe: directed corner cases, stall, reset, random traffic.
module tb_prefix_adder_pipe;

    localparam int W   = 32;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit lat_chk = 1'b0;
    bit rnd_rdy = 1'b0;
    int streak = 0;
    int max_streak = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];

    prefix_adder_pipe #(.WIDTH(W), .LVL_PER_STG(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PREFIX_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer addition on the effective operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   full;
        exp_t         e;
        yy     = s ? ~y : y;
        cc     = s ? 1'b1 : c;
        full   = {1'b0, x} + {1'b0, yy} + (W+1)'(cc);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == yy[W-1]) && (e.sum[W-1] != x[W-1]);
        e.acc  = cyc;
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    // Monitor: samples on the falling edge, pushes accepted inputs, pops on output transfer.
    initial begin : monitor
        logic         hold_prev;
        logic         xfer_prev;
        logic [W-1:0] sum_prev;
        logic         cout_prev, ovf_prev;
        exp_t         e;
        hold_prev = 1'b0;
        xfer_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (hold_prev) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_sum", sum, sum_prev);
                    check("hold_cout", cout, cout_prev);
                    check("hold_ovf", ovf, ovf_prev);
                end
                if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
                if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub));
                if (out_valid && out_ready) begin
                    streak = xfer_prev ? streak + 1 : 1;
                    if (streak > max_streak) max_streak = streak;
                    if (sb.size() == 0) begin
                        check("unexpected_result", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sum", sum, e.sum);
                        check("cout", cout, e.cout);
                        check("ovf", ovf, e.ovf);
                        if (lat_chk) check("latency", cyc - e.acc, LAT);
                    end
                end
                xfer_prev = out_valid && out_ready;
                hold_prev = out_valid && !out_ready;
                sum_prev  = sum;
                cout_prev = cout;
                ovf_prev  = ovf;
            end else begin
                hold_prev = 1'b0;
                xfer_prev = 1'b0;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        sub = s;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin : stim
        logic s;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Carry-out wrap and signed overflow corners, with latency check
        lat_chk = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        idle(1);
        drain();

        // Ten back-to-back operations must stream out on consecutive cycles
        max_streak = 0;
        for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'(i[0]), 1'b0);
        idle(1);
        drain();
        check("b2b_streak", max_streak, 10);
        lat_chk = 1'b0;

        // Fill the pipe while the consumer stalls, then release
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        idle(1);
        repeat (6) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight: none may reappear
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sum", sum, 0);
        idle(8);
        drain();

`ifdef PREFIX_ADDER_SUB_EN
        lat_chk = 1'b1;
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        idle(1);
        drain();
        lat_chk = 1'b0;
`endif

        // Random traffic with random gaps and random back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
`ifdef PREFIX_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            send(pick(), pick(), 1'($urandom_range(0, 1)), s);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
